axisv_pattern_gen: RTL and testbench

AXISV_PATTERN_GEN -- requirements
Module: axisv_pattern_gen

---
 rtl/axisv_pattern_gen.sv | 176 +++++++++++++++++
 tb/tb_axisv_pattern_gen.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axisv_pattern_gen.sv
// AXI-Stream video test pattern source (bars/ramp/checker/solid); one beat per cycle, zero startup bubble after trigger.
// Back-pressure: on tready=0 the counters and the tdata/tlast/tuser outputs hold.
module axisv_pattern_gen #(
  parameter int H_PIXEL_COUNT = 800,
  parameter int V_PIXEL_COUNT = 480,
  parameter int CHANNEL_WIDTH = 6,
  parameter int NUM_CHANNELS  = 3,
  parameter int BAR_SHIFT     = 6,
  parameter int CHECK_SHIFT   = 4,
  parameter int FRAME_GAP     = 4,
  localparam int DATA_WIDTH   = CHANNEL_WIDTH * NUM_CHANNELS
) (
  input  logic                  aclk_i,
  input  logic                  rst_ni,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  trigger_i,
  input  logic                  stop_i,
  input  logic                  continuous_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] color_i,
  output logic                  active_o,
  output logic                  frame_done_o,
  output logic [15:0]           frame_cnt_o
);

  localparam int CW = $clog2(H_PIXEL_COUNT) + 1;
  localparam int RW = $clog2(V_PIXEL_COUNT) + 1;
  localparam int GW = $clog2(FRAME_GAP + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    stop_q, stop_d;
  logic                    done_q, done_d;
  logic [1:0]              mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   color_q, color_d;

  logic                    run, beat, last_col, last_row;
  logic [2:0]              bar;
  logic                    chk;
  logic [CHANNEL_WIDTH-1:0] ramp;
  logic [DATA_WIDTH-1:0]   pat;

  assign run      = (state_q == RUN);
  assign beat     = run && m_axis_tready;
  assign last_col = (col_q == CW'(H_PIXEL_COUNT - 1));
  assign last_row = (row_q == RW'(V_PIXEL_COUNT - 1));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    color_d = color_q;
    case (state_q)
      IDLE: begin
        if (trigger_i) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
          mode_d  = mode_i;
          color_d = color_i;
          stop_d  = stop_i;
        end
      end
      RUN: begin
        if (stop_i) stop_d = 1'b1;
        if (beat) begin
          if (!last_col) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d = '0;
            if (!last_row) begin
              row_d = row_q + 1'b1;
            end else begin
              row_d  = '0;
              done_d = 1'b1;
              cnt_d  = cnt_q + 16'd1;
              if (continuous_i && !stop_q && !stop_i) begin
                // With no gap the next frame starts on the very next cycle.
                if (FRAME_GAP == 0) begin
                  mode_d  = mode_i;
                  color_d = color_i;
                end else begin
                  state_d = GAP;
                  gap_d   = '0;
                end
              end else begin
                state_d = IDLE;
                stop_d  = 1'b0;
              end
            end
          end
        end
      end
      GAP: begin
        if (stop_i) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end else if (gap_q == GW'(FRAME_GAP - 1)) begin
          state_d = RUN;
          mode_d  = mode_i;
          color_d = color_i;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      color_q <= color_d;
    end
  end

  // Pattern is a pure function of registered state, so it holds during stalls.
  assign bar  = 3'({3'b000, col_q} >> BAR_SHIFT);
  assign chk  = (((col_q >> CHECK_SHIFT) ^ CW'(row_q >> CHECK_SHIFT)) & CW'(1)) != '0;
  assign ramp = CHANNEL_WIDTH'(16'(col_q) + cnt_q);

  always_comb begin
    pat = '0;
    if (mode_q == 2'd3) begin
      pat = color_q;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (mode_q)
          2'd0:    pat[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] = {CHANNEL_WIDTH{bar[c % 3]}};
          2'd1:    pat[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] = ramp;
          default: pat[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] = {CHANNEL_WIDTH{chk}};
        endcase
      end
    end
  end

  assign m_axis_tdata  = run ? pat : '0;
  assign m_axis_tvalid = run;
  assign m_axis_tlast  = run && last_col;
  assign m_axis_tuser  = run && (col_q == '0) && (row_q == '0);
  assign active_o      = (state_q != IDLE);
  assign frame_done_o  = done_q;
  assign frame_cnt_o   = cnt_q;

endmodule

// File: tb/tb_axisv_pattern_gen.sv
// Directed bench for axisv_pattern_gen with an 8x2 frame, 6-bit RGB and a 4-cycle gap.
module tb_axisv_pattern_gen;

  localparam int DW = 18;

  logic          aclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid, tready, tlast, tuser;
  logic          trigger, stop, continuous;
  logic [1:0]    mode;
  logic [DW-1:0] color;
  logic          active, frame_done;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int errors = 0;

  axisv_pattern_gen #(
    .H_PIXEL_COUNT(8), .V_PIXEL_COUNT(2), .CHANNEL_WIDTH(6), .NUM_CHANNELS(3),
    .BAR_SHIFT(1), .CHECK_SHIFT(0), .FRAME_GAP(4)
  ) dut (
    .aclk_i(aclk), .rst_ni(rst_n),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .trigger_i(trigger), .stop_i(stop), .continuous_i(continuous),
    .mode_i(mode), .color_i(color),
    .active_o(active), .frame_done_o(frame_done), .frame_cnt_o(frame_cnt)
  );

  always #5 aclk = ~aclk;

  // Beat capture, frame_done counting, gap measurement and stall stability.
  logic [DW-1:0] bd [0:63];
  logic          bl [0:63];
  logic          bu [0:63];
  int            nbeats = 0;
  int            nfd = 0;
  int            lowrun = 0;
  int            last_gap = -1;
  logic          hold_vld = 1'b0;
  logic [DW+1:0] held;

  always @(negedge aclk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && tvalid) begin
        checks++;
        if ({tdata, tlast, tuser} !== held) begin
          errors++;
          $display("FAIL stall_stable got %h expected %h", {tdata, tlast, tuser}, held);
        end
      end
      if (tvalid && !tready) begin
        hold_vld = 1'b1;
        held = {tdata, tlast, tuser};
      end else begin
        hold_vld = 1'b0;
      end
      if (tvalid && tready) begin
        if (nbeats < 64) begin
          bd[nbeats] = tdata;
          bl[nbeats] = tlast;
          bu[nbeats] = tuser;
        end
        nbeats++;
      end
      if (frame_done) nfd++;
      if (tvalid) begin
        if (lowrun > 0) last_gap = lowrun;
        lowrun = 0;
      end else if (active) begin
        lowrun++;
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_mon();
    nbeats = 0;
    nfd = 0;
    lowrun = 0;
    last_gap = -1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    trigger = 1'b0; stop = 1'b0; continuous = 1'b0; tready = 1'b1;
    mode = 2'd0; color = '0;
    step(); step();
    clear_mon();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (!active) ok = 1'b1;
      else step();
    end
    step(); step();
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (nbeats >= n) ok = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    trigger = 1'b0; stop = 1'b0; continuous = 1'b0; tready = 1'b1;
    mode = 2'd0; color = '0;
    #3;
    checks++;
    if ({tvalid, tlast, tuser, active, frame_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 00000", {tvalid, tlast, tuser, active, frame_done});
    end
    checks++;
    if (tdata !== '0) begin
      errors++;
      $display("FAIL reset_tdata got %h expected 0", tdata);
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt got %0d expected 0", frame_cnt);
    end
    apply_reset();
    step(); step();
    checks++;
    if (tvalid !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_trigger got tvalid=%b active=%b expected 0 0", tvalid, active);
    end
  endtask

  task automatic check_solid_frame(input string tag, input logic [15:0] exp_cnt);
    checks++;
    if (nbeats !== 16) begin
      errors++;
      $display("FAIL %s_beats got %0d expected 16", tag, nbeats);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({bd[i], bl[i], bu[i]} !== {18'h0003F, (i == 7 || i == 15), (i == 0)}) begin
        errors++;
        $display("FAIL %s_beat%0d got data=%h last=%b user=%b expected data=3f last=%b user=%b",
                 tag, i, bd[i], bl[i], bu[i], (i == 7 || i == 15), (i == 0));
      end
    end
    checks++;
    if (nfd !== 1) begin
      errors++;
      $display("FAIL %s_frame_done got %0d pulses expected 1", tag, nfd);
    end
    checks++;
    if (frame_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s_frame_cnt got %0d expected %0d", tag, frame_cnt, exp_cnt);
    end
    checks++;
    if (active !== 1'b0 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got active=%b tvalid=%b expected 0 0", tag, active, tvalid);
    end
  endtask

  task automatic test_solid();
    bit ok;
    clear_mon();
    mode = 2'd3; color = 18'h0003F; tready = 1'b1;
    pulse_trigger();
    wait_idle(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL solid_timeout got active=1 expected idle within 200 cycles");
    end
    check_solid_frame("solid", 16'd1);
  endtask

  task automatic test_stall();
    int n;
    clear_mon();
    mode = 2'd3; color = 18'h0003F;
    tready = 1'b0;
    pulse_trigger();
    n = 0;
    while (active && n < 400) begin
      tready = ($urandom_range(0, 2) != 0);
      step();
      n++;
    end
    tready = 1'b1;
    step(); step();
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL stall_timeout got %0d cycles expected idle within 400", n);
    end
    check_solid_frame("stall", 16'd2);
  endtask

  task automatic test_continuous_ramp();
    bit ok;
    apply_reset();
    mode = 2'd1; continuous = 1'b1;
    pulse_trigger();
    wait_beats(17, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ramp_timeout got %0d beats expected 17", nbeats);
    end
    checks++;
    if (bd[15] !== 18'h071C7 || bd[3] !== 18'h030C3) begin
      errors++;
      $display("FAIL ramp_frame1 got b3=%h b15=%h expected 030c3 071c7", bd[3], bd[15]);
    end
    checks++;
    if (bd[16] !== 18'h01041 || bu[16] !== 1'b1) begin
      errors++;
      $display("FAIL ramp_frame2_beat0 got data=%h user=%b expected 01041 1", bd[16], bu[16]);
    end
    checks++;
    if (last_gap !== 4) begin
      errors++;
      $display("FAIL ramp_gap got %0d expected 4", last_gap);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle(200, ok);
    checks++;
    if (!ok || nbeats !== 32 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL ramp_stop got beats=%0d cnt=%0d expected 32 2", nbeats, frame_cnt);
    end
    continuous = 1'b0;
  endtask

  task automatic test_stop();
    bit ok;
    int nuser;
    apply_reset();
    mode = 2'd3; color = 18'h0003F; continuous = 1'b1;
    pulse_trigger();
    wait_beats(5, 100, ok);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle(200, ok);
    repeat (10) step();
    nuser = 0;
    for (int i = 0; i < 16; i++) if (bu[i] === 1'b1) nuser++;
    checks++;
    if (!ok || nbeats !== 16) begin
      errors++;
      $display("FAIL stop_beats got %0d expected 16", nbeats);
    end
    checks++;
    if (nuser !== 1 || nfd !== 1) begin
      errors++;
      $display("FAIL stop_user_done got tuser=%0d done=%0d expected 1 1", nuser, nfd);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stop_frame_cnt got %0d expected 1", frame_cnt);
    end
    continuous = 1'b0;
  endtask

  task automatic test_mode_change();
    bit ok;
    logic [DW-1:0] bars [0:7];
    logic [DW-1:0] exp;
    int col, row;
    bars[0] = 18'h0; bars[1] = 18'h0; bars[2] = 18'h0003F; bars[3] = 18'h0003F;
    bars[4] = 18'h00FC0; bars[5] = 18'h00FC0; bars[6] = 18'h00FFF; bars[7] = 18'h00FFF;
    apply_reset();
    mode = 2'd0; continuous = 1'b1;
    pulse_trigger();
    wait_beats(3, 100, ok);
    mode = 2'd2;
    wait_beats(17, 200, ok);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle(200, ok);
    checks++;
    if (!ok || nbeats !== 32) begin
      errors++;
      $display("FAIL mode_beats got %0d expected 32", nbeats);
    end
    for (int i = 0; i < 32; i++) begin
      col = i % 8;
      row = (i / 8) % 2;
      if (i < 16) exp = bars[col];
      else exp = (((col ^ row) & 1) != 0) ? 18'h3FFFF : 18'h0;
      checks++;
      if (bd[i] !== exp) begin
        errors++;
        $display("FAIL mode_beat%0d got %h expected %h", i, bd[i], exp);
      end
    end
    continuous = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    apply_reset();
    mode = 2'd3; color = 18'h0003F;
    pulse_trigger();
    wait_beats(5, 100, ok);
    rst_n = 1'b0;
    #1;
    checks++;
    if (tvalid !== 1'b0 || active !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_abort got tvalid=%b active=%b cnt=%0d expected 0 0 0", tvalid, active, frame_cnt);
    end
    step();
    rst_n = 1'b1;
    repeat (20) step();
    checks++;
    if (nbeats !== 5 || nfd !== 0 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet got beats=%0d done=%0d tvalid=%b expected 5 0 0", nbeats, nfd, tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_solid();
    test_stall();
    test_continuous_ramp();
    test_stop();
    test_mode_change();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
